// File: rtl/ii_decode.sv
// Streaming integral-image decoder: rebuilds each pixel from its II word and three
// neighbours (left, up, up-left) using one previous-row line buffer and a 2-stage pipeline.
module ii_decode #(
    parameter int PIXSIZE    = 8,
    parameter int IIWORDSIZE = 24,
    parameter int A_BITS     = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [IIWORDSIZE-1:0] II_i,
    input  logic                  frame_valid_i,
    input  logic                  data_valid_i,
    output logic [PIXSIZE-1:0]    Y_o,
    output logic                  frame_valid_o,
    output logic                  data_valid_o,
    output logic                  err_o
);

    localparam logic [A_BITS:0] COL_MAX = {1'b1, {A_BITS{1'b0}}};

    // input-side tracking
    logic                  fv_prev_q, fv_prev_d;
    logic                  dv_prev_q, dv_prev_d;
    logic                  armed_q, armed_d;
    logic                  first_row_q, first_row_d;
    logic [A_BITS:0]       col_q, col_d;

    // stage 1 (aligned with the line-buffer read data)
    logic [IIWORDSIZE-1:0] ii_s1_q, ii_s1_d;
    logic [A_BITS:0]       col_s1_q, col_s1_d;
    logic                  first_s1_q, first_s1_d;
    logic                  dv_s1_q, dv_s1_d;
    logic                  fv_s1_q, fv_s1_d;
    logic                  over_s1_q, over_s1_d;
    logic [IIWORDSIZE-1:0] left_q, left_d;
    logic [IIWORDSIZE-1:0] up_prev_q, up_prev_d;

    // output stage
    logic [PIXSIZE-1:0]    y_q, y_d;
    logic                  dv_o_q, dv_o_d;
    logic                  fv_o_q, fv_o_d;
    logic                  err_q, err_d;

    // line buffer
    logic [IIWORDSIZE-1:0] line_mem [2**A_BITS];
    logic [IIWORDSIZE-1:0] rd_q;
    logic [A_BITS-1:0]     rd_addr, wr_addr;
    logic                  wr_en;

    logic                  fv_rise, armed_cur, pix_valid, dv_fall, first_cur, over_cur;
    logic                  col_zero, range_bad;
    logic [IIWORDSIZE-1:0] left, up, diag, d;

    always_comb begin
        fv_rise   = frame_valid_i & ~fv_prev_q;
        armed_cur = armed_q | fv_rise;
        pix_valid = armed_cur & frame_valid_i & data_valid_i;
        dv_fall   = dv_prev_q & ~pix_valid;
        first_cur = fv_rise | first_row_q;
        over_cur  = (col_q == COL_MAX);

        fv_prev_d   = frame_valid_i;
        dv_prev_d   = pix_valid;
        armed_d     = armed_cur;
        first_row_d = first_row_q;
        if (fv_rise)
            first_row_d = 1'b1;
        else if (dv_fall)
            first_row_d = 1'b0;

        col_d = '0;
        if (pix_valid)
            col_d = over_cur ? col_q : col_q + 1'b1;

        rd_addr = col_q[A_BITS-1:0];

        ii_s1_d    = II_i;
        col_s1_d   = col_q;
        first_s1_d = first_cur;
        dv_s1_d    = pix_valid;
        fv_s1_d    = armed_cur & frame_valid_i;
        over_s1_d  = pix_valid & over_cur;
        left_d     = ii_s1_q;
        up_prev_d  = rd_q;

        // neighbour terms are masked at the left edge and on the frame's first row
        col_zero  = (col_s1_q == '0);
        left      = col_zero ? '0 : left_q;
        up        = first_s1_q ? '0 : rd_q;
        diag      = (col_zero | first_s1_q) ? '0 : up_prev_q;
        d         = ii_s1_q - left - up + diag;
        range_bad = |d[IIWORDSIZE-1:PIXSIZE];

        wr_en   = dv_s1_q & ~over_s1_q;
        wr_addr = col_s1_q[A_BITS-1:0];

        y_d    = dv_s1_q ? d[PIXSIZE-1:0] : y_q;
        dv_o_d = dv_s1_q;
        fv_o_d = fv_s1_q;
        err_d  = fv_rise ? 1'b0 : (err_q | (dv_s1_q & (range_bad | over_s1_q)));
    end

    // fv_prev resets high so a frame already running at reset release never looks like a start
    always_ff @(posedge clk) begin
        if (rst) begin
            fv_prev_q   <= 1'b1;
            dv_prev_q   <= 1'b0;
            armed_q     <= 1'b0;
            first_row_q <= 1'b0;
            col_q       <= '0;
            ii_s1_q     <= '0;
            col_s1_q    <= '0;
            first_s1_q  <= 1'b0;
            dv_s1_q     <= 1'b0;
            fv_s1_q     <= 1'b0;
            over_s1_q   <= 1'b0;
            left_q      <= '0;
            up_prev_q   <= '0;
            y_q         <= '0;
            dv_o_q      <= 1'b0;
            fv_o_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            fv_prev_q   <= fv_prev_d;
            dv_prev_q   <= dv_prev_d;
            armed_q     <= armed_d;
            first_row_q <= first_row_d;
            col_q       <= col_d;
            ii_s1_q     <= ii_s1_d;
            col_s1_q    <= col_s1_d;
            first_s1_q  <= first_s1_d;
            dv_s1_q     <= dv_s1_d;
            fv_s1_q     <= fv_s1_d;
            over_s1_q   <= over_s1_d;
            left_q      <= left_d;
            up_prev_q   <= up_prev_d;
            y_q         <= y_d;
            dv_o_q      <= dv_o_d;
            fv_o_q      <= fv_o_d;
            err_q       <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        rd_q <= line_mem[rd_addr];
        if (wr_en)
            line_mem[wr_addr] <= ii_s1_q;
    end

    assign Y_o           = y_q;
    assign data_valid_o  = dv_o_q;
    assign frame_valid_o = fv_o_q;
    assign err_o         = err_q;

endmodule

// File: tb/tb_ii_decode.sv
// Directed bench for ii_decode: bench-side integral-image generator feeds the decoder,
// outputs are captured at negedge and compared against the source pixels.
module tb_ii_decode;

    localparam int PIX = 8;
    localparam int IIW = 24;
    localparam int AB  = 10;

    logic           clk = 1'b0;
    logic           rst;
    logic [IIW-1:0] II_i;
    logic           frame_valid_i, data_valid_i;
    logic [PIX-1:0] Y_o;
    logic           frame_valid_o, data_valid_o, err_o;

    always #5 clk = ~clk;

    ii_decode #(.PIXSIZE(PIX), .IIWORDSIZE(IIW), .A_BITS(AB)) dut (
        .clk           (clk),
        .rst           (rst),
        .II_i          (II_i),
        .frame_valid_i (frame_valid_i),
        .data_valid_i  (data_valid_i),
        .Y_o           (Y_o),
        .frame_valid_o (frame_valid_o),
        .data_valid_o  (data_valid_o),
        .err_o         (err_o)
    );

    typedef struct {
        logic [PIX-1:0] y;
        logic           err;
        int unsigned    c;
    } out_t;

    int unsigned    cyc = 0;
    int             n_chk = 0;
    int             n_fail = 0;
    out_t           capq[$];
    logic [PIX-1:0] expq[$];
    int unsigned    inq[$];
    int unsigned    fvi_rise_cyc = 0, fvo_rise_cyc = 0;
    logic           fvi_last = 1'b0, fvo_prev = 1'b0;
    logic [IIW-1:0] above_ii [0:1099];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (data_valid_o) capq.push_back('{Y_o, err_o, cyc});
        if (frame_valid_o && !fvo_prev) fvo_rise_cyc = cyc;
        fvo_prev = frame_valid_o;
    end

    task automatic step(input logic fv, input logic dv, input logic [IIW-1:0] ii);
        frame_valid_i = fv;
        data_valid_i  = dv;
        II_i          = ii;
        @(posedge clk);
        #1;
        if (dv) inq.push_back(cyc);
        if (fv && !fvi_last) fvi_rise_cyc = cyc;
        fvi_last = fv;
    endtask

    task automatic clear_q();
        capq.delete();
        expq.delete();
        inq.delete();
    endtask

    function automatic logic [PIX-1:0] pix(input int pat, input int x, input int y, input int seed);
        case (pat)
            0:       return 8'd255;
            1:       return 8'((x * 17 + y * 31 + seed) & 255);
            default: return 8'd1;
        endcase
    endfunction

    // Integral image generator model; one II word may be offset by cadd to corrupt it.
    task automatic send_frame(input int w, input int h, input int pat, input int seed,
                              input int cidx, input logic [IIW-1:0] cadd, input bit lead);
        logic [IIW-1:0] rs, ii;
        logic [PIX-1:0] p;
        int             idx = 0;
        for (int x = 0; x < w; x++) above_ii[x] = '0;
        if (lead) step(1'b1, 1'b0, '0);
        for (int y = 0; y < h; y++) begin
            rs = '0;
            for (int x = 0; x < w; x++) begin
                p = pix(pat, x, y, seed);
                expq.push_back(p);
                rs = rs + 24'(p);
                ii = rs + above_ii[x];
                above_ii[x] = ii;
                step(1'b1, 1'b1, (idx == cidx) ? ii + cadd : ii);
                idx++;
            end
            if (y != h - 1) step(1'b1, 1'b0, '0);
        end
        step(1'b0, 1'b0, '0);
    endtask

    task automatic drain();
        repeat (3) step(1'b0, 1'b0, '0);
    endtask

    function automatic int y_bad(input int skip_last);
        int n = 0;
        for (int i = 0; i < capq.size() && i < expq.size() - skip_last; i++)
            if (capq[i].y !== expq[i]) n++;
        return n;
    endfunction

    function automatic int err_ones();
        int n = 0;
        foreach (capq[i]) if (capq[i].err !== 1'b0) n++;
        return n;
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        step(1'b1, 1'b1, 24'h00ABCD);
        step(1'b1, 1'b1, 24'h001234);
        n_chk += 4;
        if (Y_o !== '0)           begin n_fail++; $display("FAIL reset_y got %0d want 0", Y_o); end
        if (data_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_dv got %b want 0", data_valid_o); end
        if (frame_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_fv got %b want 0", frame_valid_o); end
        if (err_o !== 1'b0)       begin n_fail++; $display("FAIL reset_err got %b want 0", err_o); end
        rst = 1'b0;
        step(1'b0, 1'b0, '0);
        step(1'b0, 1'b0, '0);
    endtask

    task automatic test_basic_3x2();
        logic [IIW-1:0] iis [6] = '{24'd1, 24'd3, 24'd6, 24'd5, 24'd12, 24'd21};
        clear_q();
        step(1'b1, 1'b0, '0);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, iis[i]);
        step(1'b1, 1'b0, '0);
        for (int i = 3; i < 6; i++) step(1'b1, 1'b1, iis[i]);
        step(1'b0, 1'b0, '0);
        drain();
        n_chk++;
        if (capq.size() !== 6) begin n_fail++; $display("FAIL basic_count got %0d want 6", capq.size()); end
        for (int i = 0; i < capq.size() && i < 6 && i < inq.size(); i++) begin
            n_chk += 3;
            if (capq[i].y !== 8'(i + 1)) begin n_fail++; $display("FAIL basic_y[%0d] got %0d want %0d", i, capq[i].y, i + 1); end
            if (capq[i].err !== 1'b0) begin n_fail++; $display("FAIL basic_err[%0d] got %b want 0", i, capq[i].err); end
            if (capq[i].c !== inq[i] + 1) begin n_fail++; $display("FAIL basic_latency[%0d] got cycle %0d want %0d", i, capq[i].c, inq[i] + 1); end
        end
        n_chk++;
        if (fvo_rise_cyc !== fvi_rise_cyc + 1) begin
            n_fail++; $display("FAIL basic_fv_latency got cycle %0d want %0d", fvo_rise_cyc, fvi_rise_cyc + 1);
        end
    endtask

    task automatic test_back_to_back();
        clear_q();
        send_frame(5, 3, 1, 0, -1, '0, 1'b0);
        send_frame(5, 3, 1, 100, -1, '0, 1'b0);
        drain();
        n_chk += 3;
        if (capq.size() !== 30) begin n_fail++; $display("FAIL b2b_count got %0d want 30", capq.size()); end
        if (y_bad(0) !== 0) begin n_fail++; $display("FAIL b2b_pixels got %0d bad want 0", y_bad(0)); end
        if (err_ones() !== 0) begin n_fail++; $display("FAIL b2b_err got %0d flagged want 0", err_ones()); end
    endtask

    task automatic test_corrupt();
        int ebad = 0;
        clear_q();
        send_frame(4, 3, 1, 7, 5, 24'd256, 1'b1);
        drain();
        foreach (capq[i]) if (capq[i].err !== (i >= 5)) ebad++;
        n_chk += 4;
        if (capq.size() !== 12) begin n_fail++; $display("FAIL corrupt_count got %0d want 12", capq.size()); end
        if (y_bad(0) !== 0) begin n_fail++; $display("FAIL corrupt_lowbyte got %0d bad want 0", y_bad(0)); end
        if (ebad !== 0) begin n_fail++; $display("FAIL corrupt_err_seq got %0d wrong want 0", ebad); end
        if (err_o !== 1'b1) begin n_fail++; $display("FAIL corrupt_sticky got %b want 1", err_o); end
        step(1'b1, 1'b0, '0);
        n_chk++;
        if (err_o !== 1'b0) begin n_fail++; $display("FAIL corrupt_clear_on_rise got %b want 0", err_o); end
        step(1'b0, 1'b0, '0);
        clear_q();
        send_frame(4, 3, 1, 9, -1, '0, 1'b1);
        drain();
        n_chk += 2;
        if (y_bad(0) !== 0 || capq.size() !== 12) begin n_fail++; $display("FAIL corrupt_next_frame got %0d bad of %0d want 0 of 12", y_bad(0), capq.size()); end
        if (err_ones() !== 0) begin n_fail++; $display("FAIL corrupt_next_err got %0d flagged want 0", err_ones()); end
    endtask

    task automatic test_mid_reset();
        int nsize;
        clear_q();
        step(1'b1, 1'b0, '0);
        step(1'b1, 1'b1, 24'd1);
        step(1'b1, 1'b1, 24'd259);
        step(1'b1, 1'b1, 24'd6);
        step(1'b1, 1'b0, '0);
        step(1'b1, 1'b1, 24'd5);
        step(1'b1, 1'b1, 24'd12);
        n_chk += 3;
        if (Y_o !== 8'd4) begin n_fail++; $display("FAIL midrst_pre_y got %0d want 4", Y_o); end
        if (data_valid_o !== 1'b1) begin n_fail++; $display("FAIL midrst_pre_dv got %b want 1", data_valid_o); end
        if (err_o !== 1'b1) begin n_fail++; $display("FAIL midrst_pre_err got %b want 1", err_o); end
        rst = 1'b1;
        step(1'b1, 1'b1, 24'd21);
        rst = 1'b0;
        nsize = capq.size();
        n_chk += 4;
        if (Y_o !== '0) begin n_fail++; $display("FAIL midrst_y got %0d want 0", Y_o); end
        if (data_valid_o !== 1'b0) begin n_fail++; $display("FAIL midrst_dv got %b want 0", data_valid_o); end
        if (frame_valid_o !== 1'b0) begin n_fail++; $display("FAIL midrst_fv got %b want 0", frame_valid_o); end
        if (err_o !== 1'b0) begin n_fail++; $display("FAIL midrst_err got %b want 0", err_o); end
        step(1'b1, 1'b0, '0);
        step(1'b1, 1'b1, 24'd1);
        step(1'b1, 1'b1, 24'd2);
        step(1'b0, 1'b0, '0);
        drain();
        n_chk++;
        if (capq.size() !== nsize) begin n_fail++; $display("FAIL midrst_dropped got %0d outputs want %0d", capq.size(), nsize); end
        clear_q();
        send_frame(3, 4, 1, 55, -1, '0, 1'b1);
        drain();
        n_chk++;
        if (y_bad(0) !== 0 || capq.size() !== 12 || err_ones() !== 0)
            begin n_fail++; $display("FAIL midrst_next_frame got %0d bad of %0d want 0 of 12", y_bad(0), capq.size()); end
    endtask

    task automatic test_overlength();
        int ebad = 0;
        clear_q();
        send_frame(1025, 1, 2, 0, -1, '0, 1'b1);
        drain();
        foreach (capq[i]) if (capq[i].err !== (i == 1024)) ebad++;
        n_chk += 3;
        if (capq.size() !== 1025) begin n_fail++; $display("FAIL overlen_count got %0d want 1025", capq.size()); end
        if (y_bad(1) !== 0) begin n_fail++; $display("FAIL overlen_pixels got %0d bad want 0", y_bad(1)); end
        if (ebad !== 0) begin n_fail++; $display("FAIL overlen_err_seq got %0d wrong want 0", ebad); end
        clear_q();
        send_frame(4, 3, 1, 21, -1, '0, 1'b1);
        drain();
        n_chk += 2;
        if (y_bad(0) !== 0 || capq.size() !== 12) begin n_fail++; $display("FAIL overlen_next_frame got %0d bad of %0d want 0 of 12", y_bad(0), capq.size()); end
        if (err_ones() !== 0) begin n_fail++; $display("FAIL overlen_next_err got %0d flagged want 0", err_ones()); end
    endtask

    task automatic test_loopback_wrap();
        clear_q();
        send_frame(256, 257, 0, 0, -1, '0, 1'b1);
        drain();
        n_chk += 3;
        if (capq.size() !== 65792) begin n_fail++; $display("FAIL wrap_count got %0d want 65792", capq.size()); end
        if (y_bad(0) !== 0) begin n_fail++; $display("FAIL wrap_pixels got %0d bad want 0", y_bad(0)); end
        if (err_ones() !== 0) begin n_fail++; $display("FAIL wrap_err got %0d flagged want 0", err_ones()); end
    endtask

    initial begin
        rst = 1'b1;
        frame_valid_i = 1'b0;
        data_valid_i = 1'b0;
        II_i = '0;
        test_reset();
        test_basic_3x2();
        test_back_to_back();
        test_corrupt();
        test_mid_reset();
        test_overlength();
        test_loopback_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
